// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - state type and shared constants for nibble_serializer
// SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_GAP   = 0;
  localparam int GAP_CNT_W = 4;

`ifdef SERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_bits(input int width);
    return width + (PARITY_EN ? 1 : 0);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load, shift-right register presenting bit0
// Zeros shift in from the top, so the register drains to 0 after a frame.
module piso_shift_reg #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_d,
  output logic         o_bit0
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= {1'b0, r_q[W-1:1]};
    end
  end

  assign o_bit0 = r_q[0];

endmodule

// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - LSB-first word serializer with framing and inter-frame gap
// Parity frame bit enabled by SERIALIZER_PARITY_EN.
module nibble_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             Dout,
  output logic             Dvalid,
  output logic             Dlast,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = frame_bits(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_PEN  = CW'(WIDTH - 2);
  localparam logic [GAP_CNT_W-1:0] G_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit B2B = (GAP == 0);

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [GAP_CNT_W-1:0]   r_gcnt;
  logic                   r_dvalid;
  logic                   r_dlast;
  logic                   w_accept;
  logic                   w_shift;
  logic                   w_frame_end;
  logic [SW-1:0]          w_word;

  // Dlast marks the final frame bit, which is also the back-to-back accept slot.
  assign din_ready   = RST & ((r_state == S_IDLE) | (B2B & r_dlast));
  assign w_accept    = din_valid & din_ready;
  assign w_shift     = (r_state == S_SHIFT) | (r_state == S_PARITY);
  assign w_frame_end = (r_state == S_PARITY) |
                       ((r_state == S_SHIFT) & (r_cnt == C_LAST) & ~PARITY_EN);

  if (SW > WIDTH) begin : g_par
    assign w_word = {^din, din};
  end else begin : g_data
    assign w_word = din;
  end

  piso_shift_reg #(.W(SW)) u_shreg (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_d     (w_word),
    .o_bit0  (Dout)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_gcnt   <= '0;
      r_dvalid <= 1'b0;
      r_dlast  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_SHIFT;
            r_cnt    <= '0;
            r_dvalid <= 1'b1;
            r_dlast  <= 1'b0;
          end
        end
        S_SHIFT, S_PARITY: begin
          if (w_frame_end) begin
            r_cnt <= '0;
            if (GAP != 0) begin
              r_state  <= S_GAP;
              r_gcnt   <= '0;
              r_dvalid <= 1'b0;
              r_dlast  <= 1'b0;
            end else if (w_accept) begin
              r_state  <= S_SHIFT;
              r_dvalid <= 1'b1;
              r_dlast  <= 1'b0;
            end else begin
              r_state  <= S_IDLE;
              r_dvalid <= 1'b0;
              r_dlast  <= 1'b0;
            end
          end else if (r_cnt == C_LAST) begin
            r_state <= S_PARITY;
            r_cnt   <= '0;
            r_dlast <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_dlast <= ~PARITY_EN & (r_cnt == C_PEN);
          end
        end
        S_GAP: begin
          if (r_gcnt == G_LAST) begin
            r_state <= S_IDLE;
            r_gcnt  <= '0;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Dvalid = r_dvalid;
  assign Dlast  = r_dlast;
  assign busy   = (r_state != S_IDLE);

endmodule
